// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl
// Description : Run/stop/single-step controller for the 8-bit upcounter.
//               Converts three asynchronous operator levels (start, stop,
//               step) into one-cycle enable pulses at a prescaled rate and
//               halts when the fed-back count equals a programmable limit.
// Ports       : clk50m  - system clock, all logic on the rising edge
//               rst_n   - asynchronous active-low reset
//               start   - async level, rising edge requests RUN
//               stop    - async level, rising edge requests IDLE
//               step    - async level, rising edge requests one count in IDLE
//               count   - current counter value fed back from the upcounter
//               limit   - terminal value, compared live
//               enable  - registered one-cycle pulse to the upcounter
//               running - high in RUN
//               done    - high in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl #(
    parameter int PRESCALE = 5_000_000
) (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic [7:0] count,
    input  logic [7:0] limit,
    output logic       enable,
    output logic       running,
    output logic       done
);

    localparam int                   c_presc_w    = $clog2(PRESCALE);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESCALE - 1);
    localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);

    // Encoding chosen so that running and done are plain flop bits.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t               r_state;
    logic [c_presc_w-1:0] r_presc;
    logic                 r_enable;

    // Bit order in the synchronizer vectors: {step, stop, start}
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_sync_d;

    logic [2:0] w_edge;
    logic       w_start_ev;
    logic       w_stop_ev;
    logic       w_step_ev;
    logic       w_at_limit;

    // Two-flop synchronizers followed by a delay flop for edge detection.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 3'b000;
            r_sync2  <= 3'b000;
            r_sync_d <= 3'b000;
        end else begin
            r_sync1  <= {step, stop, start};
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync_d;

    // Priority stop > start > step; losers in the same cycle are dropped.
    assign w_stop_ev  = w_edge[1];
    assign w_start_ev = w_edge[0] & ~w_edge[1];
    assign w_step_ev  = w_edge[2] & ~w_edge[1] & ~w_edge[0];
    assign w_at_limit = (count == limit);

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_enable <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ev) begin
                        r_presc <= '0;
                        if (w_at_limit) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else if (w_step_ev) begin
                        r_enable <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_stop_ev) begin
                        r_state <= S_IDLE;
                        r_presc <= '0;
                    end else if (w_at_limit && !r_enable) begin
                        // While enable is high the count is about to change,
                        // so the compare is only trusted with enable low.
                        r_state <= S_DONE;
                        r_presc <= '0;
                    end else if (r_presc == c_presc_last) begin
                        r_presc  <= '0;
                        r_enable <= !w_at_limit;
                    end else begin
                        r_presc <= r_presc + c_presc_one;
                    end
                end
                S_DONE: begin
                    r_presc <= '0;
                    if (w_stop_ev) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_presc <= '0;
                end
            endcase
        end
    end

    assign enable  = r_enable;
    assign running = r_state[0];
    assign done    = r_state[1];

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_ctrl
// Description : Directed self-checking bench for counter_ctrl with a small
//               upcounter model closing the count feedback loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;

    localparam int PRESCALE = 4;

    logic       clk50m   = 1'b0;
    logic       rst_n    = 1'b1;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       step     = 1'b0;
    logic [7:0] cnt      = 8'd0;
    logic [7:0] limit    = 8'd0;
    logic       enable;
    logic       running;
    logic       done;

    logic       load_en  = 1'b0;
    logic [7:0] load_val = 8'd0;

    int errors = 0;
    int checks = 0;

    int n_pulse, first_pulse, last_pulse, run_rise, run_fall, done_rise, bad_gap;

    counter_ctrl #(.PRESCALE(PRESCALE)) dut (
        .clk50m  (clk50m),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .step    (step),
        .count   (cnt),
        .limit   (limit),
        .enable  (enable),
        .running (running),
        .done    (done)
    );

    always #10 clk50m = ~clk50m;

    // Upcounter model with a bench-side load port
    always @(posedge clk50m) begin
        if (load_en)     cnt <= load_val;
        else if (enable) cnt <= cnt + 8'd1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic load_count(input logic [7:0] v);
        @(negedge clk50m);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk50m);
        load_en  = 1'b0;
    endtask

    task automatic apply_reset;
        start = 1'b0; stop = 1'b0; step = 1'b0;
        @(negedge clk50m);
        rst_n = 1'b0;
        @(negedge clk50m);
        rst_n = 1'b1;
    endtask

    // Runs n cycles; cycle i is sampled at the negedge after the i-th posedge
    // following the call. Releases all operator inputs after cycle rel.
    task automatic run_cycles(input int n, input int rel);
        logic prev_run, prev_done;
        n_pulse = 0; first_pulse = -1; last_pulse = -1;
        run_rise = -1; run_fall = -1; done_rise = -1; bad_gap = 0;
        prev_run  = running;
        prev_done = done;
        for (int i = 0; i < n; i++) begin
            @(posedge clk50m);
            @(negedge clk50m);
            if (enable) begin
                if (last_pulse >= 0 && (i - last_pulse) != PRESCALE) bad_gap++;
                if (first_pulse < 0) first_pulse = i;
                last_pulse = i;
                n_pulse++;
            end
            if (running && !prev_run && run_rise < 0)  run_rise  = i;
            if (!running && prev_run && run_fall < 0)  run_fall  = i;
            if (done && !prev_done && done_rise < 0)   done_rise = i;
            prev_run  = running;
            prev_done = done;
            if (i == rel) begin
                start = 1'b0; stop = 1'b0; step = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        #7 rst_n = 1'b0;
        #99;
        checks++; if (enable !== 1'b0)  begin errors++; $display("FAIL reset_enable: got %b expected 0", enable); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk50m);
        rst_n = 1'b1;
    endtask

    task automatic test_step;
        load_count(8'd0);
        limit = 8'd10;
        @(negedge clk50m);
        step = 1'b1;
        run_cycles(10, 2);
        checks++; if (n_pulse !== 1)     begin errors++; $display("FAIL step_pulses: got %0d expected 1", n_pulse); end
        checks++; if (first_pulse !== 2) begin errors++; $display("FAIL step_latency: got %0d expected 2", first_pulse); end
        checks++; if (cnt !== 8'd1)      begin errors++; $display("FAIL step_count: got %0d expected 1", cnt); end
        checks++; if (running !== 1'b0)  begin errors++; $display("FAIL step_running: got %b expected 0", running); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL step_done: got %b expected 0", done); end
    endtask

    task automatic test_run_to_limit;
        apply_reset();
        load_count(8'd0);
        limit = 8'd5;
        @(negedge clk50m);
        start = 1'b1;
        run_cycles(40, 2);
        checks++; if (run_rise !== 2)    begin errors++; $display("FAIL run_rise: got %0d expected 2", run_rise); end
        checks++; if (first_pulse !== 6) begin errors++; $display("FAIL run_first_pulse: got %0d expected 6", first_pulse); end
        checks++; if (n_pulse !== 5)     begin errors++; $display("FAIL run_pulses: got %0d expected 5", n_pulse); end
        checks++; if (bad_gap !== 0)     begin errors++; $display("FAIL run_spacing: got %0d bad gaps expected 0", bad_gap); end
        checks++; if (last_pulse !== 22) begin errors++; $display("FAIL run_last_pulse: got %0d expected 22", last_pulse); end
        checks++; if (done_rise !== 24)  begin errors++; $display("FAIL run_done_rise: got %0d expected 24", done_rise); end
        checks++; if (run_fall !== 24)   begin errors++; $display("FAIL run_fall: got %0d expected 24", run_fall); end
        checks++; if (cnt !== 8'd5)      begin errors++; $display("FAIL run_count: got %0d expected 5", cnt); end
    endtask

    task automatic test_wrap;
        apply_reset();
        load_count(8'd250);
        limit = 8'd3;
        @(negedge clk50m);
        start = 1'b1;
        run_cycles(50, 2);
        checks++; if (n_pulse !== 9)     begin errors++; $display("FAIL wrap_pulses: got %0d expected 9", n_pulse); end
        checks++; if (bad_gap !== 0)     begin errors++; $display("FAIL wrap_spacing: got %0d bad gaps expected 0", bad_gap); end
        checks++; if (last_pulse !== 38) begin errors++; $display("FAIL wrap_last_pulse: got %0d expected 38", last_pulse); end
        checks++; if (done_rise !== 40)  begin errors++; $display("FAIL wrap_done_rise: got %0d expected 40", done_rise); end
        checks++; if (cnt !== 8'd3)      begin errors++; $display("FAIL wrap_count: got %0d expected 3", cnt); end
    endtask

    task automatic test_stop_priority;
        apply_reset();
        load_count(8'd0);
        limit = 8'd100;
        @(negedge clk50m);
        start = 1'b1;
        run_cycles(13, 2);
        checks++; if (n_pulse !== 2)     begin errors++; $display("FAIL stop_pre_pulses: got %0d expected 2", n_pulse); end
        stop = 1'b1;
        run_cycles(20, 4);
        // Pulse already scheduled before the stop event lands, then none.
        checks++; if (n_pulse !== 1)     begin errors++; $display("FAIL stop_post_pulses: got %0d expected 1", n_pulse); end
        checks++; if (first_pulse !== 1) begin errors++; $display("FAIL stop_last_pulse: got %0d expected 1", first_pulse); end
        checks++; if (run_fall !== 2)    begin errors++; $display("FAIL stop_run_fall: got %0d expected 2", run_fall); end
        checks++; if (cnt !== 8'd3)      begin errors++; $display("FAIL stop_count: got %0d expected 3", cnt); end

        start = 1'b1; stop = 1'b1; step = 1'b1;
        run_cycles(10, 2);
        checks++; if (n_pulse !== 0)     begin errors++; $display("FAIL all3_pulses: got %0d expected 0", n_pulse); end
        checks++; if (running !== 1'b0)  begin errors++; $display("FAIL all3_running: got %b expected 0", running); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL all3_done: got %b expected 0", done); end

        start = 1'b1; step = 1'b1;
        run_cycles(8, 2);
        checks++; if (run_rise !== 2)    begin errors++; $display("FAIL startstep_run_rise: got %0d expected 2", run_rise); end
        checks++; if (first_pulse !== 6) begin errors++; $display("FAIL startstep_first_pulse: got %0d expected 6", first_pulse); end
        checks++; if (n_pulse !== 1)     begin errors++; $display("FAIL startstep_pulses: got %0d expected 1", n_pulse); end
        stop = 1'b1;
        run_cycles(6, 2);
        checks++; if (running !== 1'b0)  begin errors++; $display("FAIL startstep_stop: got %b expected 0", running); end
    endtask

    task automatic test_start_at_limit;
        apply_reset();
        load_count(8'd7);
        limit = 8'd7;
        @(negedge clk50m);
        start = 1'b1;
        run_cycles(8, 2);
        checks++; if (done_rise !== 2)   begin errors++; $display("FAIL atlim_done_rise: got %0d expected 2", done_rise); end
        checks++; if (n_pulse !== 0)     begin errors++; $display("FAIL atlim_pulses: got %0d expected 0", n_pulse); end
        checks++; if (run_rise !== -1)   begin errors++; $display("FAIL atlim_run_rise: got %0d expected -1", run_rise); end
        step = 1'b1;
        run_cycles(8, 2);
        checks++; if (n_pulse !== 0)     begin errors++; $display("FAIL atlim_step_pulses: got %0d expected 0", n_pulse); end
        checks++; if (done !== 1'b1)     begin errors++; $display("FAIL atlim_step_done: got %b expected 1", done); end
        stop = 1'b1;
        run_cycles(8, 2);
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL atlim_stop_done: got %b expected 0", done); end
        checks++; if (running !== 1'b0)  begin errors++; $display("FAIL atlim_stop_running: got %b expected 0", running); end
        checks++; if (cnt !== 8'd7)      begin errors++; $display("FAIL atlim_count: got %0d expected 7", cnt); end
    endtask

    task automatic test_reset_midrun;
        apply_reset();
        load_count(8'd0);
        limit = 8'd100;
        @(negedge clk50m);
        start = 1'b1;
        run_cycles(7, 2);
        checks++; if (enable !== 1'b1)   begin errors++; $display("FAIL midrun_pre_enable: got %b expected 1", enable); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (enable !== 1'b0)   begin errors++; $display("FAIL midrun_enable: got %b expected 0", enable); end
        checks++; if (running !== 1'b0)  begin errors++; $display("FAIL midrun_running: got %b expected 0", running); end
        @(negedge clk50m);
        rst_n = 1'b1;
        run_cycles(12, -1);
        checks++; if (n_pulse !== 0)     begin errors++; $display("FAIL midrun_post_pulses: got %0d expected 0", n_pulse); end
        checks++; if (running !== 1'b0)  begin errors++; $display("FAIL midrun_post_running: got %b expected 0", running); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_to_limit();
        test_wrap();
        test_stop_priority();
        test_start_at_limit();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_ctrl.md
# counter_ctrl

Run/stop/single-step controller for the 8-bit upcounter. It turns three asynchronous operator inputs (start, stop, step) into one-cycle `enable` pulses at a prescaled rate. It watches the counter's `count` output and halts at a programmable limit. It sits between the board pushbuttons/switches and the upcounter's `enable` input, and shares `clk50m`/`rst_n` with it.

## Interface
- `PRESCALE`, default 5_000_000: clock cycles between enable pulses in RUN (10 Hz at 50 MHz). Legal range ≥ 2; set to 4 in simulation.
- `clk50m`  in  1  system clock, 50 MHz, all logic on rising edge
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low
- `start`  in  1  asynchronous level, active-high; rising edge requests RUN
- `stop`  in  1  asynchronous level, active-high; rising edge requests IDLE
- `step`  in  1  asynchronous level, active-high; rising edge requests one count in IDLE
- `count`  in  8  current counter value, fed back from the upcounter
- `limit`  in  8  terminal value; quasi-static, compared live
- `enable`  out  1  registered, one-cycle pulse to the upcounter
- `running`  out  1  high in RUN
- `done`  out  1  high in DONE

## Operation
- Each of `start`, `stop` and `step` passes through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~sync2_d). The result is a one-cycle internal event.
- Event priority in the same cycle: stop > start > step. Lower-priority events that cycle are discarded.
- States: IDLE (reset), RUN, DONE.
  - IDLE
    - start with count ≠ limit → RUN, prescaler cleared to 0.
    - start with count == limit → DONE directly, no pulse.
    - step → `enable` high for exactly one cycle; stay in IDLE. No limit check applies.
    - stop → no effect.
  - RUN
    - stop → IDLE; prescaler cleared.
    - count == limit, sampled while `enable` is low → DONE; no further pulses.
    - Otherwise the prescaler counts 0..PRESCALE-1 and wraps. On the edge where the prescaler equals PRESCALE-1 and count ≠ limit, `enable` is set for one cycle.
    - start and step are ignored.
  - DONE
    - stop → IDLE.
    - start and step are ignored.
- Wrap-around: the 8-bit count rolls from 255 to 0 inside the counter. The controller only checks equality with `limit`, so a limit below the start value is reached after the wrap.
- Prescaler width is ceil(log2(PRESCALE)). It holds at 0 outside RUN.
- `running` and `done` are decoded from registered state and are glitch-free.

## Timing
- Reset values: `enable`=0, `running`=0, `done`=0, state IDLE, prescaler 0, synchronizer and edge flops 0.
- Reset assertion clears all outputs immediately, without a clock edge.
- Reset asserted mid-RUN drops `enable` asynchronously. After release the block stays in IDLE until a new start edge.
- Event latency: an input edge first sampled at clock edge E0 updates state/outputs at E2.
  - For step, `enable` is high from E2 to E3.
- RUN pulses:
  - First `enable` rises PRESCALE cycles after `running` rises.
  - Subsequent pulses repeat every PRESCALE cycles and are always 1 cycle wide.
- Counter loop: `enable` high at edge A → count updates at A+1 → limit compare is valid from A+2. PRESCALE ≥ 2 guarantees no pulse is issued on a stale count.
- Transition to DONE happens the first edge where count == limit with `enable` low. That is 2 cycles after the pulse that produced the limit value.
- Input pulses shorter than one clock period may be missed; the operator must hold inputs ≥ 2 cycles.

## Test plan
- **Reset:** hold rst_n=0 for 99 ns, asynchronous to the clock → enable/running/done = 0. Assert rst_n mid-RUN → enable=0 and running=0 immediately, with no clock edge.
- **Single step:** IDLE, count=0, limit=10, one step edge held 3 cycles → exactly one 1-cycle enable pulse, 2 edges after the first sampling edge; count=1; state stays IDLE.
- **Run to limit:** PRESCALE=4, count=0, limit=5, start edge → running=1.
  - Enable pulses are every 4 cycles, 5 in total.
  - done=1 two cycles after the 5th pulse; no sixth pulse; running=0.
- **Wrap-around:** count=250, limit=3, start → 9 pulses (250→255→0→3), then done=1.
- **Stop/priority:**
  - During RUN, stop → IDLE with no further pulses.
  - start, stop and step edges in the same cycle from IDLE → stays IDLE, enable=0.
  - start and step together → RUN, no step pulse.
- **Start at limit:** count=limit=7, start → done=1 with zero enable pulses. Step ignored in DONE. Stop → IDLE, done=0.
